// File: rtl/matrix_mul_seq_if.sv
// Operand/result stream bundle for matrix_mul_seq: one valid/ready word stream in,
// one valid/ready result stream out, plus the busy status flag.
interface matrix_mul_seq_if #(
  parameter int W = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_last;
  logic         busy;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last, busy
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last, busy
  );
endinterface

// File: rtl/matrix_mul_seq.sv
// Sequential N x N unsigned matrix multiplier C = A*B around a single shared MAC.
// Define MATMUL_SAT_EN to saturate results to W bits instead of wrapping.
module matrix_mul_seq #(
  parameter int N = 2,
  parameter int W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  matrix_mul_seq_if.slave    bus
);

  localparam int ACC_W = 2*W + $clog2(N);
  localparam int IW    = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N-1);
  localparam logic [IW-1:0] ZERO_IDX = {IW{1'b0}};

  typedef enum logic [1:0] {
    ST_LOAD_A  = 2'd0,
    ST_LOAD_B  = 2'd1,
    ST_COMPUTE = 2'd2,
    ST_DRAIN   = 2'd3
  } state_t;

  function automatic logic [W-1:0] reduce_sum(input logic [ACC_W-1:0] s);
`ifdef MATMUL_SAT_EN
    if (s > ACC_W'({W{1'b1}})) begin
      reduce_sum = {W{1'b1}};
    end else begin
      reduce_sum = s[W-1:0];
    end
`else
    reduce_sum = s[W-1:0];
`endif
  endfunction

  state_t             state_q, state_d;
  logic [IW-1:0]      ld_row_q, ld_row_d, ld_col_q, ld_col_d;
  logic [IW-1:0]      i_q, i_d, j_q, j_d, k_q, k_d;
  logic [IW-1:0]      dr_row_q, dr_row_d, dr_col_q, dr_col_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               out_last_q, out_last_d;
  logic               busy_q, busy_d;
  logic [W-1:0]       out_data_q, out_data_d;

  logic [W-1:0]       mat_a [N][N];
  logic [W-1:0]       mat_b [N][N];
  logic [W-1:0]       mat_c [N][N];

  logic               accept, a_we, b_we, c_we;
  logic [ACC_W-1:0]   prod, sum;
  logic [W-1:0]       c_wdata;
  logic               ld_last, dr_last, k_wrap, j_wrap, i_wrap;
  logic [IW-1:0]      ld_row_nx, ld_col_nx, dr_row_nx, dr_col_nx;

  assign accept    = bus.in_valid && in_ready_q;
  assign ld_last   = (ld_row_q == LAST_IDX) && (ld_col_q == LAST_IDX);
  assign ld_col_nx = (ld_col_q == LAST_IDX) ? ZERO_IDX : ld_col_q + IW'(1);
  assign ld_row_nx = (ld_col_q != LAST_IDX) ? ld_row_q :
                     ((ld_row_q == LAST_IDX) ? ZERO_IDX : ld_row_q + IW'(1));
  assign dr_last   = (dr_row_q == LAST_IDX) && (dr_col_q == LAST_IDX);
  assign dr_col_nx = (dr_col_q == LAST_IDX) ? ZERO_IDX : dr_col_q + IW'(1);
  assign dr_row_nx = (dr_col_q != LAST_IDX) ? dr_row_q :
                     ((dr_row_q == LAST_IDX) ? ZERO_IDX : dr_row_q + IW'(1));
  assign k_wrap    = (k_q == LAST_IDX);
  assign j_wrap    = (j_q == LAST_IDX);
  assign i_wrap    = (i_q == LAST_IDX);

  // Next-state, counter and output computation for the load/compute/drain sequence.
  always_comb begin
    state_d     = state_q;
    ld_row_d    = ld_row_q;
    ld_col_d    = ld_col_q;
    i_d         = i_q;
    j_d         = j_q;
    k_d         = k_q;
    dr_row_d    = dr_row_q;
    dr_col_d    = dr_col_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    a_we        = 1'b0;
    b_we        = 1'b0;
    c_we        = 1'b0;
    // Product fits 2W bits, so the ACC_W-wide multiply never truncates.
    prod        = ACC_W'(mat_a[i_q][k_q]) * ACC_W'(mat_b[k_q][j_q]);
    sum         = (k_q == ZERO_IDX) ? prod : (acc_q + prod);
    c_wdata     = reduce_sum(sum);
    case (state_q)
      ST_LOAD_A: begin
        if (accept) begin
          a_we     = 1'b1;
          ld_row_d = ld_row_nx;
          ld_col_d = ld_col_nx;
          state_d  = ld_last ? ST_LOAD_B : ST_LOAD_A;
        end else begin
          a_we     = 1'b0;
        end
      end
      ST_LOAD_B: begin
        if (accept) begin
          b_we     = 1'b1;
          ld_row_d = ld_row_nx;
          ld_col_d = ld_col_nx;
          state_d  = ld_last ? ST_COMPUTE : ST_LOAD_B;
        end else begin
          b_we     = 1'b0;
        end
      end
      ST_COMPUTE: begin
        acc_d = sum;
        c_we  = k_wrap;
        k_d   = k_wrap ? ZERO_IDX : k_q + IW'(1);
        j_d   = !k_wrap ? j_q : (j_wrap ? ZERO_IDX : j_q + IW'(1));
        i_d   = !(k_wrap && j_wrap) ? i_q : (i_wrap ? ZERO_IDX : i_q + IW'(1));
        if (k_wrap && j_wrap && i_wrap) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_COMPUTE;
        end
      end
      ST_DRAIN: begin
        // First drain cycle only primes the output register from C[0][0].
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          out_data_d  = mat_c[dr_row_q][dr_col_q];
          out_last_d  = dr_last;
        end else if (bus.out_ready) begin
          if (dr_last) begin
            state_d     = ST_LOAD_A;
            dr_row_d    = ZERO_IDX;
            dr_col_d    = ZERO_IDX;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            out_data_d  = {W{1'b0}};
          end else begin
            dr_row_d    = dr_row_nx;
            dr_col_d    = dr_col_nx;
            out_data_d  = mat_c[dr_row_nx][dr_col_nx];
            out_last_d  = (dr_row_nx == LAST_IDX) && (dr_col_nx == LAST_IDX);
          end
        end else begin
          out_valid_d = out_valid_q;
        end
      end
      default: begin
        state_d = ST_LOAD_A;
      end
    endcase
    in_ready_d = (state_d == ST_LOAD_A) || (state_d == ST_LOAD_B);
    busy_d     = (state_d == ST_COMPUTE) || (state_d == ST_DRAIN);
  end

  // Control state, counters and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_LOAD_A;
      ld_row_q    <= ZERO_IDX;
      ld_col_q    <= ZERO_IDX;
      i_q         <= ZERO_IDX;
      j_q         <= ZERO_IDX;
      k_q         <= ZERO_IDX;
      dr_row_q    <= ZERO_IDX;
      dr_col_q    <= ZERO_IDX;
      acc_q       <= {ACC_W{1'b0}};
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      out_data_q  <= {W{1'b0}};
    end else begin
      state_q     <= state_d;
      ld_row_q    <= ld_row_d;
      ld_col_q    <= ld_col_d;
      i_q         <= i_d;
      j_q         <= j_d;
      k_q         <= k_d;
      dr_row_q    <= dr_row_d;
      dr_col_q    <= dr_col_d;
      acc_q       <= acc_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      out_data_q  <= out_data_d;
    end
  end

  // Operand and result storage; never reset because the drain only reads freshly written C.
  always_ff @(posedge clk) begin
    if (a_we) begin
      mat_a[ld_row_q][ld_col_q] <= bus.in_data;
    end
    if (b_we) begin
      mat_b[ld_row_q][ld_col_q] <= bus.in_data;
    end
    if (c_we) begin
      mat_c[i_q][j_q] <= c_wdata;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_matrix_mul_seq.sv
// Self-checking bench for matrix_mul_seq: an N=2/W=8 and an N=3/W=16 instance checked
// every cycle against a plain-arithmetic matrix model (honours MATMUL_SAT_EN).
module tb_matrix_mul_seq;

`ifdef MATMUL_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef longint unsigned mat_t [9];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst2_n, rst3_n;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  bit   armed = 1'b0;
  bit   lat_arm = 1'b0;
  int   lat_t = 0;
  bit   rnd3 = 1'b0;

  longint unsigned exp2_d[$];
  bit              exp2_l[$];
  longint unsigned exp3_d[$];
  bit              exp3_l[$];

  matrix_mul_seq_if #(.W(8))  bus2();
  matrix_mul_seq_if #(.W(16)) bus3();

  matrix_mul_seq #(.N(2), .W(8))  dut2 (.clk(clk), .rst_n(rst2_n), .bus(bus2));
  matrix_mul_seq #(.N(3), .W(16)) dut3 (.clk(clk), .rst_n(rst3_n), .bus(bus3));

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model(input int n, input int w, input mat_t a, input mat_t b,
                                output mat_t c);
    longint unsigned mask, s;
    mask = (64'd1 << w) - 64'd1;
    for (int q = 0; q < 9; q++) c[q] = 0;
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < n; j++) begin
        s = 0;
        for (int k = 0; k < n; k++) s += a[i*n+k] * b[k*n+j];
        if (SAT && s > mask) c[i*n+j] = mask;
        else c[i*n+j] = s & mask;
      end
    end
  endfunction

  // Per-cycle monitor of one instance against the expected-output queue.
  task automatic mon(input int sel);
    logic ov, ordy, ol, bz, ir;
    logic [63:0] od;
    int qs;
    bit pending;
    if (sel == 0) begin
      ov = bus2.out_valid; ordy = bus2.out_ready; ol = bus2.out_last;
      bz = bus2.busy; ir = bus2.in_ready; od = 64'(bus2.out_data); qs = exp2_d.size();
    end else begin
      ov = bus3.out_valid; ordy = bus3.out_ready; ol = bus3.out_last;
      bz = bus3.busy; ir = bus3.in_ready; od = 64'(bus3.out_data); qs = exp3_d.size();
    end
    pending = (qs != 0);
    check(sel == 0 ? "busy2" : "busy3", 64'(bz), 64'(pending));
    check(sel == 0 ? "in_ready2" : "in_ready3", 64'(ir), 64'(!pending));
    if (sel == 0 && lat_arm && ov) begin
      check("latency2", 64'(cyc - lat_t), 64'd9);
      lat_arm = 1'b0;
    end
    if (!ov) begin
      check(sel == 0 ? "last_idle2" : "last_idle3", 64'(ol), 64'd0);
    end else if (qs == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL unexpected_out%0d: got out_valid=1 data=%0d required no output", sel, od);
    end else if (sel == 0) begin
      check("data2", od, exp2_d[0]);
      check("last2", 64'(ol), 64'(exp2_l[0]));
      if (ordy) begin
        void'(exp2_d.pop_front());
        void'(exp2_l.pop_front());
      end
    end else begin
      check("data3", od, exp3_d[0]);
      check("last3", 64'(ol), 64'(exp3_l[0]));
      if (ordy) begin
        void'(exp3_d.pop_front());
        void'(exp3_l.pop_front());
      end
    end
  endtask

  always @(negedge clk) begin
    if (armed) begin
      mon(0);
      mon(1);
    end
  end

  task automatic send(input int sel, input longint unsigned d, input int gap);
    bit ok;
    if (gap > 0) begin
      if (sel == 0) begin bus2.in_valid = 1'b0; bus2.in_data = 8'hA5; end
      else begin bus3.in_valid = 1'b0; bus3.in_data = 16'hDEAD; end
      repeat (gap) begin @(posedge clk); #1; end
    end
    if (sel == 0) begin bus2.in_valid = 1'b1; bus2.in_data = 8'(d); end
    else begin bus3.in_valid = 1'b1; bus3.in_data = 16'(d); end
    ok = 1'b0;
    for (int t = 0; t < 1000 && !ok; t++) begin
      @(negedge clk);
      ok = (sel == 0) ? bus2.in_ready : bus3.in_ready;
    end
    if (!ok) begin
      n_cmp++;
      n_fail++;
      $display("FAIL accept_timeout%0d: got in_ready=0 for 1000 cycles required 1", sel);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic load_pair(input int sel, input mat_t a, input mat_t b, input bit arm,
                           input int maxgap);
    int n, w;
    mat_t c;
    n = (sel == 0) ? 2 : 3;
    w = (sel == 0) ? 8 : 16;
    for (int q = 0; q < n*n; q++) send(sel, a[q], (maxgap == 0) ? 0 : int'($urandom_range(0, maxgap)));
    for (int q = 0; q < n*n; q++) send(sel, b[q], (maxgap == 0) ? 0 : int'($urandom_range(0, maxgap)));
    if (sel == 0) bus2.in_valid = 1'b0;
    else bus3.in_valid = 1'b0;
    model(n, w, a, b, c);
    for (int q = 0; q < n*n; q++) begin
      if (sel == 0) begin exp2_d.push_back(c[q]); exp2_l.push_back(q == n*n-1); end
      else begin exp3_d.push_back(c[q]); exp3_l.push_back(q == n*n-1); end
    end
    if (arm) begin
      lat_t   = cyc;
      lat_arm = 1'b1;
    end
  endtask

  task automatic wait_drain(input int sel);
    int qs;
    qs = 1;
    for (int t = 0; t < 3000 && qs != 0; t++) begin
      @(negedge clk);
      qs = (sel == 0) ? exp2_d.size() : exp3_d.size();
    end
    if (qs != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain_timeout%0d: got %0d results outstanding required 0", sel, qs);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset2();
    check("rst_in_ready", 64'(bus2.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus2.out_valid), 64'd0);
    check("rst_out_last", 64'(bus2.out_last), 64'd0);
    check("rst_busy", 64'(bus2.busy), 64'd0);
    check("rst_out_data", 64'(bus2.out_data), 64'd0);
  endtask

  // Random out_ready stalls on the N=3 instance while enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd3) bus3.out_ready = 1'(($urandom_range(0, 1)));
      else bus3.out_ready = 1'b1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    mat_t a, b, c;
    rst2_n = 1'b0; rst3_n = 1'b0;
    bus2.in_valid = 1'b0; bus2.in_data = 8'd0; bus2.out_ready = 1'b1;
    bus3.in_valid = 1'b0; bus3.in_data = 16'd0; bus3.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst2_n = 1'b1; rst3_n = 1'b1;
    chk_reset2();
    check("rst3_in_ready", 64'(bus3.in_ready), 64'd1);
    check("rst3_out_valid", 64'(bus3.out_valid), 64'd0);
    armed = 1'b1;

    // 1: basic product, constant in_valid, latency check
    a = '{1, 2, 3, 4, 0, 0, 0, 0, 0};
    b = '{5, 6, 7, 8, 0, 0, 0, 0, 0};
    model(2, 8, a, b, c);
    check("pin_t1_c00", c[0], 64'd19);
    check("pin_t1_c01", c[1], 64'd22);
    check("pin_t1_c10", c[2], 64'd43);
    check("pin_t1_c11", c[3], 64'd50);
    load_pair(0, a, b, 1'b1, 0);
    wait_drain(0);

    // 2: all-255 operands: wrap or saturate
    a = '{255, 255, 255, 255, 0, 0, 0, 0, 0};
    model(2, 8, a, a, c);
    check("pin_t2_c00", c[0], SAT ? 64'd255 : 64'd2);
    load_pair(0, a, a, 1'b0, 0);
    wait_drain(0);

    // 3: N=3 identity times 1..9 with input gaps and output stalls
    a = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
    b = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    model(3, 16, a, b, c);
    for (int q = 0; q < 9; q++) check("pin_t3", c[q], 64'(q + 1));
    rnd3 = 1'b1;
    load_pair(1, a, b, 1'b0, 2);
    wait_drain(1);
    rnd3 = 1'b0;

    // 4: reset after 3 B words, then a fresh pair
    for (int q = 0; q < 4; q++) send(0, 64'(q + 9), 0);
    for (int q = 0; q < 3; q++) send(0, 64'(q + 3), 0);
    bus2.in_valid = 1'b0;
    rst2_n = 1'b0;
    @(posedge clk);
    #1;
    rst2_n = 1'b1;
    chk_reset2();
    a = '{2, 0, 0, 2, 0, 0, 0, 0, 0};
    b = '{1, 1, 1, 1, 0, 0, 0, 0, 0};
    model(2, 8, a, b, c);
    check("pin_t4_c00", c[0], 64'd2);
    check("pin_t4_c11", c[3], 64'd2);
    load_pair(0, a, b, 1'b0, 0);
    wait_drain(0);

    // 5: back-to-back pairs with a 5-cycle stall mid-drain of the first
    a = '{1, 0, 2, 1, 0, 0, 0, 0, 0};
    b = '{3, 4, 5, 6, 0, 0, 0, 0, 0};
    model(2, 8, a, b, c);
    check("pin_t5_c10", c[2], 64'd11);
    check("pin_t5_c11", c[3], 64'd14);
    load_pair(0, a, b, 1'b0, 0);
    a = '{10, 20, 30, 40, 0, 0, 0, 0, 0};
    b = '{1, 2, 3, 4, 0, 0, 0, 0, 0};
    model(2, 8, a, b, c);
    check("pin_t5b_c00", c[0], 64'd70);
    check("pin_t5b_c11", c[3], 64'd220);
    fork
      load_pair(0, a, b, 1'b0, 0);
      begin
        for (int t = 0; t < 1000 && exp2_d.size() > 2; t++) @(negedge clk);
        @(posedge clk);
        #1;
        bus2.out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        bus2.out_ready = 1'b1;
      end
    join
    wait_drain(0);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
